// File: rtl/fb_pkg.sv
// Framebuffer geometry, pixel writer state encoding and the (x,y) to word
// address mapping shared by every block that touches the 1-bpp framebuffer.
package fb_pkg;

    localparam int H_RES          = 640;
    localparam int V_RES          = 480;
    localparam int WORDS_PER_LINE = H_RES / 16;
    localparam int FB_WORDS       = WORDS_PER_LINE * V_RES;
    localparam int ADDR_W         = 18;
    localparam int ERASE_W        = 15;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        ER_REQ,
        ER_WAIT
    } pw_state_t;

    // Word address of a pixel: y*40 + x/16, built from shifts so no multiplier
    // is needed; the caller passes x[9:4] as the word column.
    function automatic logic [ADDR_W-1:0] xy_to_addr(input logic [5:0] x_word,
                                                     input logic [9:0] y);
        logic [ADDR_W-1:0] y_ext;
        y_ext = ADDR_W'(y);
        return (y_ext << 5) + (y_ext << 3) + ADDR_W'(x_word);
    endfunction

endpackage

// File: rtl/sram_req.sv
// SRAM handshake engine: issues a one-cycle read or write strobe when the
// controller is idle and the bus is granted, then reports completion on the
// first ready cycle at least two cycles after the strobe.
module sram_req (
    input  logic clk,
    input  logic reset,
    input  logic rd_req,
    input  logic wr_req,
    input  logic ready,
    input  logic bus_free,
    output logic read,
    output logic write,
    output logic done
);

    logic       active;
    logic [1:0] age;
    logic       can_start;

    assign can_start = ready && bus_free && !active;
    assign read      = rd_req && can_start;
    assign write     = wr_req && !rd_req && can_start;
    assign done      = active && ready && (age == 2'd2);

    // Track the in-flight operation and its age since the strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active <= 1'b0;
            age    <= 2'd0;
        end else if (read || write) begin
            active <= 1'b1;
            age    <= 2'd1;
        end else if (done) begin
            active <= 1'b0;
            age    <= 2'd0;
        end else if (active && (age != 2'd2)) begin
            age <= age + 2'd1;
        end
    end

endmodule

// File: rtl/pixel_writer.sv
// Write-side framebuffer initiator: sets one pixel per accepted pen point with
// a read-modify-write, or sweeps zeros over the whole framebuffer on an erase
// button press. SRAM access only starts while bus_free is granted.
module pixel_writer
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              point_valid,
    input  logic              erase_button,
    input  logic              bus_free,
    input  logic              ready,
    input  logic [15:0]       data_read,
    output logic [ADDR_W-1:0] address,
    output logic [15:0]       data_write,
    output logic              read,
    output logic              write,
    output logic              busy,
    output logic              erasing
);

    pw_state_t          state;
    logic [ADDR_W-1:0]  pt_addr;
    logic [3:0]         pt_bit;
    logic               point_pending;
    logic               erase_pending;
    logic               erase_q;
    logic [ERASE_W-1:0] erase_cnt;

    logic               rd_req;
    logic               wr_req;
    logic               done;
    logic               on_screen;
    logic               accept;
    logic               erase_edge;
    logic               erase_req;
    logic [ADDR_W-1:0]  new_addr;

    assign on_screen  = (x < 10'(H_RES)) && (y < 10'(V_RES));
    assign accept     = point_valid && !busy && on_screen;
    assign new_addr   = xy_to_addr(x[9:4], y);
    assign erase_edge = erase_button && !erase_q;
    assign erase_req  = erase_pending || (erase_edge && !erasing);
    assign rd_req     = (state == RD_REQ);
    assign wr_req     = (state == WR_REQ) || (state == ER_REQ);

    sram_req u_sram_req (
        .clk      (clk),
        .reset    (reset),
        .rd_req   (rd_req),
        .wr_req   (wr_req),
        .ready    (ready),
        .bus_free (bus_free),
        .read     (read),
        .write    (write),
        .done     (done)
    );

    // Remember the previous button level so a press is seen only once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            erase_q <= 1'b0;
        end else begin
            erase_q <= erase_button;
        end
    end

    // Main sequencer: point read-modify-write and erase sweep share one bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            address       <= '0;
            data_write    <= 16'h0000;
            busy          <= 1'b0;
            erasing       <= 1'b0;
            pt_addr       <= '0;
            pt_bit        <= 4'd0;
            point_pending <= 1'b0;
            erase_pending <= 1'b0;
            erase_cnt     <= '0;
        end else begin
            if (erase_edge && !erasing) begin
                erase_pending <= 1'b1;
            end
            if (accept) begin
                pt_addr <= new_addr;
                pt_bit  <= x[3:0];
            end
            case (state)
                IDLE: begin
                    if (erase_req) begin
                        state         <= ER_REQ;
                        erase_pending <= 1'b0;
                        erasing       <= 1'b1;
                        busy          <= 1'b1;
                        address       <= ADDR_W'(erase_cnt);
                        data_write    <= 16'h0000;
                        if (accept) begin
                            point_pending <= 1'b1;
                        end
                    end else if (accept) begin
                        state   <= RD_REQ;
                        busy    <= 1'b1;
                        address <= new_addr;
                    end else if (point_pending) begin
                        state         <= RD_REQ;
                        busy          <= 1'b1;
                        point_pending <= 1'b0;
                        address       <= pt_addr;
                    end
                end
                RD_REQ: begin
                    if (read) begin
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (done) begin
                        data_write <= data_read | (16'h0001 << pt_bit);
                        state      <= WR_REQ;
                    end
                end
                WR_REQ: begin
                    if (write) begin
                        state <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (done) begin
                        state <= IDLE;
                        busy  <= erase_req;
                    end
                end
                ER_REQ: begin
                    if (write) begin
                        state <= ER_WAIT;
                    end
                end
                ER_WAIT: begin
                    if (done) begin
                        if (erase_cnt == ERASE_W'(FB_WORDS - 1)) begin
                            erase_cnt <= '0;
                            erasing   <= 1'b0;
                            busy      <= point_pending;
                            state     <= IDLE;
                        end else begin
                            erase_cnt <= erase_cnt + 1'b1;
                            address   <= ADDR_W'(erase_cnt + 1'b1);
                            state     <= ER_REQ;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_writer.sv
// Testbench for pixel_writer: a behavioural SRAM answers strobes, a monitor
// checks every strobe against a queue of expected operations.
module tb_pixel_writer;
    import fb_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic [9:0]        x;
    logic [9:0]        y;
    logic              point_valid;
    logic              erase_button;
    logic              bus_free;
    logic              ready = 1'b1;
    logic [15:0]       data_read = 16'h0000;
    logic [ADDR_W-1:0] address;
    logic [15:0]       data_write;
    logic              read;
    logic              write;
    logic              busy;
    logic              erasing;

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } op_t;

    typedef struct {
        logic [9:0]        px;
        logic [9:0]        py;
        logic [15:0]       rd;
        logic              hit;
        logic [ADDR_W-1:0] addr;
        logic [15:0]       wd;
    } vec_t;

    op_t         exp_q[$];
    vec_t        vecs[9];
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] rd_value = 16'h0000;
    logic        sweep_done;

    always #5 clk = ~clk;

    pixel_writer dut (
        .clk          (clk),
        .reset        (reset),
        .x            (x),
        .y            (y),
        .point_valid  (point_valid),
        .erase_button (erase_button),
        .bus_free     (bus_free),
        .ready        (ready),
        .data_read    (data_read),
        .address      (address),
        .data_write   (data_write),
        .read         (read),
        .write        (write),
        .busy         (busy),
        .erasing      (erasing)
    );

    // SRAM model: ready drops for one cycle after a strobe, read data is
    // presented from the cycle after the strobe and held.
    always @(posedge clk) begin
        if (reset) begin
            ready     <= 1'b1;
            data_read <= 16'h0000;
        end else if (read || write) begin
            ready <= 1'b0;
            if (read) data_read <= rd_value;
        end else begin
            ready <= 1'b1;
        end
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Every strobe must match the next expected operation and occur on a granted, idle bus.
    always @(negedge clk) begin
        if (!reset && (read || write)) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("[TB] FAIL unexpected_strobe: got read=%0b write=%0b address=%0d data_write=%h, required no strobe",
                         read, write, address, data_write);
            end else begin
                op_t e;
                e = exp_q.pop_front();
                check_output("strobe",
                    64'({write, read, address, (write ? data_write : 16'h0000), bus_free, ready}),
                    64'({e.wr, ~e.wr, e.addr, (e.wr ? e.data : 16'h0000), 1'b1, 1'b1}));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_op(input logic wr, input logic [ADDR_W-1:0] a, input logic [15:0] d);
        op_t o;
        o.wr   = wr;
        o.addr = a;
        o.data = d;
        exp_q.push_back(o);
    endtask

    // Drive a one-cycle point strobe; returns in the cycle after it was sampled.
    task automatic apply_stimulus(input logic [9:0] px, input logic [9:0] py);
        step();
        x           = px;
        y           = py;
        point_valid = 1'b1;
        step();
        point_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while (busy && n < max_cycles) begin
            step();
            n++;
        end
        check_output("busy_falls", 64'(busy), 64'(0));
    endtask

    initial begin
        vecs[0] = '{10'd50,   10'd50,   16'h0000, 1'b1, 18'd2003,  16'h0004};
        vecs[1] = '{10'd639,  10'd479,  16'h1234, 1'b1, 18'd19199, 16'h9234};
        vecs[2] = '{10'd640,  10'd10,   16'h0000, 1'b0, 18'd0,     16'h0000};
        vecs[3] = '{10'd10,   10'd480,  16'h0000, 1'b0, 18'd0,     16'h0000};
        vecs[4] = '{10'd0,    10'd0,    16'h0000, 1'b1, 18'd0,     16'h0001};
        vecs[5] = '{10'd15,   10'd0,    16'h7FFF, 1'b1, 18'd0,     16'hFFFF};
        vecs[6] = '{10'd16,   10'd1,    16'h00F0, 1'b1, 18'd41,    16'h00F1};
        vecs[7] = '{10'd1023, 10'd1023, 16'h0000, 1'b0, 18'd0,     16'h0000};
        vecs[8] = '{10'd320,  10'd240,  16'h8000, 1'b1, 18'd9620,  16'h8001};

        reset        = 1'b1;
        x            = 10'd0;
        y            = 10'd0;
        point_valid  = 1'b0;
        erase_button = 1'b0;
        bus_free     = 1'b1;
        sweep_done   = 1'b0;
        repeat (3) step();
        check_output("reset_address",    64'(address),    64'(0));
        check_output("reset_data_write", 64'(data_write), 64'(0));
        check_output("reset_strobes",    64'({read, write}), 64'(0));
        check_output("reset_busy",       64'(busy),       64'(0));
        check_output("reset_erasing",    64'(erasing),    64'(0));
        reset = 1'b0;
        step();

        // Minimum latency point, with a second point ignored while busy.
        rd_value = 16'h0000;
        expect_op(1'b0, 18'd2003, 16'h0000);
        expect_op(1'b1, 18'd2003, 16'h0004);
        apply_stimulus(10'd50, 10'd50);
        check_output("lat_c1_read",  64'({read, busy, address}), 64'({1'b1, 1'b1, 18'd2003}));
        step();
        check_output("lat_c2_noread", 64'(read), 64'(0));
        x           = 10'd100;
        y           = 10'd100;
        point_valid = 1'b1;
        step();
        point_valid = 1'b0;
        step();
        check_output("lat_c4_write", 64'({write, address, data_write}), 64'({1'b1, 18'd2003, 16'h0004}));
        step();
        step();
        check_output("lat_c6_busy", 64'(busy), 64'(1));
        step();
        check_output("lat_c7_idle", 64'(busy), 64'(0));
        repeat (10) step();
        check_output("lat_queue_empty", 64'(exp_q.size()), 64'(0));

        // Table of points: on-screen mapping, bit placement, off-screen drops.
        for (int i = 0; i < 9; i++) begin
            logic saw_busy;
            rd_value = vecs[i].rd;
            if (vecs[i].hit) begin
                expect_op(1'b0, vecs[i].addr, 16'h0000);
                expect_op(1'b1, vecs[i].addr, vecs[i].wd);
            end
            apply_stimulus(vecs[i].px, vecs[i].py);
            check_output("vec_busy", 64'(busy), 64'(vecs[i].hit));
            if (vecs[i].hit) begin
                wait_idle(50);
            end else begin
                saw_busy = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    if (busy) saw_busy = 1'b1;
                    step();
                end
                check_output("offscreen_busy", 64'(saw_busy), 64'(0));
            end
            repeat (4) step();
            check_output("vec_queue_empty", 64'(exp_q.size()), 64'(0));
        end

        // bus_free low on entry, then falling between the read and the write.
        bus_free = 1'b0;
        rd_value = 16'h0001;
        expect_op(1'b0, 18'd12, 16'h0000);
        expect_op(1'b1, 18'd12, 16'h0101);
        apply_stimulus(10'd200, 10'd0);
        for (int i = 0; i < 5; i++) begin
            check_output("hold_no_read", 64'({read, busy, address}), 64'({1'b0, 1'b1, 18'd12}));
            step();
        end
        bus_free = 1'b1;
        step();
        bus_free = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check_output("hold_no_write", 64'(write), 64'(0));
            step();
        end
        check_output("hold_data_write", 64'(data_write), 64'(16'h0101));
        check_output("hold_write_pending", 64'(exp_q.size()), 64'(1));
        bus_free = 1'b1;
        wait_idle(50);
        check_output("hold_queue_empty", 64'(exp_q.size()), 64'(0));

        // Erase edge during the point read: RMW finishes, then sweep starts at 0.
        rd_value = 16'h0000;
        expect_op(1'b0, 18'd2003, 16'h0000);
        expect_op(1'b1, 18'd2003, 16'h0004);
        for (int a = 0; a < 5; a++) expect_op(1'b1, ADDR_W'(a), 16'h0000);
        apply_stimulus(10'd50, 10'd50);
        step();
        erase_button = 1'b1;
        step();
        erase_button = 1'b0;
        begin
            int n;
            n = 0;
            while (exp_q.size() != 0 && n < 200) begin
                step();
                n++;
            end
        end
        check_output("rmw_then_erase_done", 64'(exp_q.size()), 64'(0));
        check_output("rmw_then_erase_flags", 64'({busy, erasing}), 64'({1'b1, 1'b1}));
        // Reset mid-sweep: everything returns to zero at once and is not resumed.
        reset = 1'b1;
        #1;
        check_output("rst_erase_outputs",
            64'({address, data_write, read, write, busy, erasing}), 64'(0));
        exp_q.delete();
        step();
        reset = 1'b0;
        repeat (20) step();

        // Reset during the write wait, then a normal point afterwards.
        expect_op(1'b0, 18'd2003, 16'h0000);
        expect_op(1'b1, 18'd2003, 16'h0004);
        apply_stimulus(10'd50, 10'd50);
        begin
            int n;
            n = 0;
            while (exp_q.size() != 0 && n < 50) begin
                step();
                n++;
            end
        end
        check_output("wr_wait_reached", 64'({exp_q.size() == 0, busy, data_write}), 64'({1'b1, 1'b1, 16'h0004}));
        reset = 1'b1;
        #1;
        check_output("rst_wr_outputs",
            64'({address, data_write, read, write, busy, erasing}), 64'(0));
        exp_q.delete();
        step();
        reset = 1'b0;
        step();
        expect_op(1'b0, 18'd86, 16'h0000);
        expect_op(1'b1, 18'd86, 16'h0010);
        apply_stimulus(10'd100, 10'd2);
        check_output("post_reset_busy", 64'(busy), 64'(1));
        wait_idle(50);
        repeat (4) step();
        check_output("post_reset_queue", 64'(exp_q.size()), 64'(0));

        // Full sweep with bus_free toggling and a second press mid-sweep.
        for (int a = 0; a < FB_WORDS; a++) expect_op(1'b1, ADDR_W'(a), 16'h0000);
        bus_free     = 1'b1;
        erase_button = 1'b1;
        step();
        erase_button = 1'b0;
        check_output("sweep_started", 64'({busy, erasing}), 64'({1'b1, 1'b1}));
        fork
            begin
                while (!sweep_done) begin
                    bus_free = 1'b1;
                    for (int i = 0; i < 120 && !sweep_done; i++) step();
                    if (!sweep_done) begin
                        bus_free = 1'b0;
                        for (int i = 0; i < 20 && !sweep_done; i++) step();
                    end
                end
                bus_free = 1'b1;
            end
            begin
                int  n;
                logic pulsed;
                n      = 0;
                pulsed = 1'b0;
                while (erasing && n < 80000) begin
                    step();
                    n++;
                    if (!pulsed && exp_q.size() < 10000) begin
                        erase_button = 1'b1;
                        pulsed       = 1'b1;
                    end else if (erase_button) begin
                        erase_button = 1'b0;
                    end
                end
                erase_button = 1'b0;
                check_output("sweep_erasing_falls", 64'(erasing), 64'(0));
                check_output("sweep_all_written", 64'(exp_q.size()), 64'(0));
                sweep_done = 1'b1;
            end
        join
        repeat (300) step();
        check_output("sweep_no_restart", 64'({exp_q.size() == 0, busy, erasing}), 64'({1'b1, 1'b0, 1'b0}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
